// File: rtl/dac_spi_pkg.sv
// Shared frame layout, FSM encoding and frame builder for the DAC SPI transmitter.
// Frame: {WR=0, BUF, GA_n, SHDN_n=1, data[9:0], 2'b00}, sent MSB first.
package dac_spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int DATA_W   = 10;

  localparam int WR_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_LDAC  = 3'd4;

  // Sample lands directly below SHDN_n; the two LSBs are don't-care zeros.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [DATA_W-1:0] data,
    input logic              buf_en,
    input logic              gain_1x
  );
    logic [FRAME_W-1:0] f;
    f                       = '0;
    f[WR_BIT]               = 1'b0;
    f[BUF_BIT]              = buf_en;
    f[GA_BIT]               = gain_1x;
    f[SHDN_BIT]             = 1'b1;
    f[SHDN_BIT-1 -: DATA_W] = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample input strobe and DAC serial pins; master drives samples, slave is the transmitter.
interface dac_spi_tx_if;
  import dac_spi_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              dac_cs;
  logic              dac_sck;
  logic              dac_sdi;
  logic              dac_ld;
  logic              busy;

  modport master (
    output data_in, load,
    input  dac_cs, dac_sck, dac_sdi, dac_ld, busy
  );

  modport slave (
    input  data_in, load,
    output dac_cs, dac_sck, dac_sdi, dac_ld, busy
  );

endinterface

// File: rtl/sck_tick_gen.sv
// Half-period timer: one-cycle half_tick every CLK_DIV enabled cycles; count held at 0 while disabled.
module sck_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  output logic half_tick
);

  localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign half_tick = en && (cnt == LAST);

  always_ff @(posedge sysclk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI frame transmitter for a 10-bit DAC with a one-deep newest-wins sample holding register.
// Define DAC_SPI_TX_LDAC_EN to add the LDAC pulse phase; otherwise dac_ld is tied low.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter bit BUF_EN  = 1'b0,
  parameter bit GAIN_1X = 1'b1
) (
  input  logic         sysclk,
  input  logic         reset,
  dac_spi_tx_if.slave  bus
);

  logic [2:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [3:0]         bit_cnt;
  logic [DATA_W-1:0]  hold;
  logic               pend;
  logic               cs;
  logic               sck;
  logic               busy_r;
  logic               half_tick;
  logic [FRAME_W-1:0] start_frame;

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .sysclk    (sysclk),
    .reset     (reset),
    .en        (state != ST_IDLE),
    .half_tick (half_tick)
  );

  // A held sample always takes priority over a fresh strobe at frame start.
  assign start_frame = build_frame(pend ? hold : bus.data_in, BUF_EN, GAIN_1X);

  assign bus.dac_cs  = cs;
  assign bus.dac_sck = sck;
  assign bus.dac_sdi = shreg[FRAME_W-1];
  assign bus.busy    = busy_r;

`ifdef DAC_SPI_TX_LDAC_EN
  logic ld;
  assign bus.dac_ld = ld;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      ld <= 1'b1;
    end else if (state == ST_STOP && half_tick) begin
      ld <= 1'b0;
    end else if (state == ST_LDAC && half_tick) begin
      ld <= 1'b1;
    end
  end
`else
  assign bus.dac_ld = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      hold    <= '0;
      pend    <= 1'b0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      // Strobes arriving while a frame runs (or while a held start is launching) are parked.
      if (bus.load && (state != ST_IDLE || pend)) begin
        hold <= bus.data_in;
        pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pend || bus.load) begin
            shreg   <= start_frame;
            bit_cnt <= 4'd15;
            cs      <= 1'b0;
            busy_r  <= 1'b1;
            state   <= ST_START;
            if (pend && !bus.load) begin
              pend <= 1'b0;
            end
          end
        end

        ST_START: begin
          if (half_tick) begin
            sck   <= 1'b1;
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (half_tick) begin
            if (sck) begin
              // Data advances only on the falling edge of SCK.
              sck <= 1'b0;
              if (bit_cnt != 4'd0) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
              end
            end else if (bit_cnt == 4'd0) begin
              cs    <= 1'b1;
              shreg <= '0;
              state <= ST_STOP;
            end else begin
              sck     <= 1'b1;
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (half_tick) begin
`ifdef DAC_SPI_TX_LDAC_EN
            state <= ST_LDAC;
`else
            busy_r <= 1'b0;
            state  <= ST_IDLE;
`endif
          end
        end

`ifdef DAC_SPI_TX_LDAC_EN
        ST_LDAC: begin
          if (half_tick) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: two instances (CLK_DIV=4 defaults, and CLK_DIV=1 with BUF=1/GA_n=0).
module tb_dac_spi_tx;

`ifdef DAC_SPI_TX_LDAC_EN
  localparam bit HAS_LDAC = 1'b1;
`else
  localparam bit HAS_LDAC = 1'b0;
`endif
  localparam int LEN = HAS_LDAC ? 35 : 34;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  dac_spi_tx_if bus_a ();
  dac_spi_tx_if bus_b ();

  dac_spi_tx #(.CLK_DIV(4)) dut_a (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_a)
  );

  dac_spi_tx #(.CLK_DIV(1), .BUF_EN(1'b1), .GAIN_1X(1'b0)) dut_b (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_b)
  );

  logic [1:0] m_busy, m_cs, m_sck, m_sdi, m_ld;
  assign m_busy = {bus_b.busy,    bus_a.busy};
  assign m_cs   = {bus_b.dac_cs,  bus_a.dac_cs};
  assign m_sck  = {bus_b.dac_sck, bus_a.dac_sck};
  assign m_sdi  = {bus_b.dac_sdi, bus_a.dac_sdi};
  assign m_ld   = {bus_b.dac_ld,  bus_a.dac_ld};

  // Per-frame records captured by the pin monitor.
  logic [15:0] r_word [2][16];
  int          r_busy [2][16];
  int          r_cs   [2][16];
  int          r_ld   [2][16];
  int          r_bits [2][16];
  int          r_bad  [2][16];
  int          r_gap  [2][16];
  int          nfr    [2];

  bit          in_fr    [2];
  bit          prev_sck [2];
  logic        prev_sdi [2];
  int          last_rise[2];
  logic [15:0] w        [2];
  int          c_busy[2], c_cs[2], c_ld[2], c_bits[2], c_bad[2], c_gap[2], idle_run[2];
  int          cyc;
  int          div_of [2];

  initial begin
    div_of[0] = 4;
    div_of[1] = 1;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      nfr[d] = 0; in_fr[d] = 1'b0; prev_sck[d] = 1'b0; prev_sdi[d] = 1'b0; idle_run[d] = 0;
    end
  end

  always @(negedge sysclk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] === 1'b1) begin
        if (!in_fr[d]) begin
          in_fr[d] = 1'b1; c_gap[d] = idle_run[d];
          c_busy[d] = 0; c_cs[d] = 0; c_ld[d] = 0; c_bits[d] = 0; c_bad[d] = 0;
          w[d] = '0; last_rise[d] = -1;
        end
        c_busy[d]++;
        if (m_cs[d] === 1'b0) c_cs[d]++;
        if (m_ld[d] === 1'b0) c_ld[d]++;
        if (m_sck[d] === 1'b1 && !prev_sck[d]) begin
          w[d] = {w[d][14:0], m_sdi[d]};
          c_bits[d]++;
          if (last_rise[d] >= 0 && (cyc - last_rise[d]) != 2 * div_of[d]) c_bad[d]++;
          last_rise[d] = cyc;
        end
        // SDI must not move while SCK is high.
        if (m_sck[d] === 1'b1 && prev_sck[d] && m_sdi[d] !== prev_sdi[d]) c_bad[d]++;
      end else begin
        if (in_fr[d]) begin
          if (nfr[d] < 16) begin
            r_word[d][nfr[d]] = w[d];      r_busy[d][nfr[d]] = c_busy[d];
            r_cs[d][nfr[d]]   = c_cs[d];   r_ld[d][nfr[d]]   = c_ld[d];
            r_bits[d][nfr[d]] = c_bits[d]; r_bad[d][nfr[d]]  = c_bad[d];
            r_gap[d][nfr[d]]  = c_gap[d];
          end
          nfr[d]++;
          in_fr[d] = 1'b0;
          idle_run[d] = 1;
        end else begin
          idle_run[d]++;
        end
      end
      prev_sck[d] = (m_sck[d] === 1'b1);
      prev_sdi[d] = m_sdi[d];
    end
  end

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int d, input int n, input int budget);
    int t;
    t = 0;
    while (nfr[d] < n && t < budget) begin
      @(negedge sysclk);
      t++;
    end
    chk("frame_wait", 32'(nfr[d] >= n), 32'd1);
    @(negedge sysclk);
  endtask

  task automatic load_a(input logic [9:0] v);
    @(negedge sysclk);
    bus_a.data_in = v;
    bus_a.load    = 1'b1;
    @(negedge sysclk);
    bus_a.load    = 1'b0;
  endtask

  initial begin
    bus_a.data_in = '0; bus_a.load = 1'b0;
    bus_b.data_in = '0; bus_b.load = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);

    chk("rst_cs",   bus_a.dac_cs,  1'b1);
    chk("rst_sck",  bus_a.dac_sck, 1'b0);
    chk("rst_sdi",  bus_a.dac_sdi, 1'b0);
    chk("rst_busy", bus_a.busy,    1'b0);
    chk("rst_ld",   bus_a.dac_ld,  HAS_LDAC);
    chk("rst_busy_b", bus_b.busy,  1'b0);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);

    // Single sample 0x200 at CLK_DIV=4.
    load_a(10'h200);
    wait_frames(0, 1, 400);
    chk("f200_word", r_word[0][0], 16'h3800);
    chk("f200_busy", r_busy[0][0], LEN * 4);
    chk("f200_cs",   r_cs[0][0],   132);
    chk("f200_bits", r_bits[0][0], 16);
    chk("f200_timing", r_bad[0][0], 0);
    chk("f200_ld",   r_ld[0][0],   HAS_LDAC ? 4 : LEN * 4);
    chk("idle_ld",   bus_a.dac_ld, HAS_LDAC);

    // Back-to-back strobes: second one is parked and follows immediately.
    @(negedge sysclk);
    bus_a.data_in = 10'h3FF; bus_a.load = 1'b1;
    @(negedge sysclk);
    bus_a.data_in = 10'h000;
    @(negedge sysclk);
    bus_a.load = 1'b0;
    wait_frames(0, 3, 800);
    chk("b2b_word1", r_word[0][1], 16'h3FFC);
    chk("b2b_word2", r_word[0][2], 16'h3000);
    chk("b2b_gap",   r_gap[0][2],  1);
    chk("b2b_busy2", r_busy[0][2], LEN * 4);

    // Two loads during one frame: newest wins, older one is dropped.
    load_a(10'h123);
    repeat (20) @(negedge sysclk);
    load_a(10'h111);
    repeat (10) @(negedge sysclk);
    load_a(10'h222);
    wait_frames(0, 5, 800);
    chk("nw_word_a", r_word[0][3], 16'h348C);
    chk("nw_word_b", r_word[0][4], 16'h3888);
    chk("nw_gap",    r_gap[0][4],  1);
    repeat (300) @(negedge sysclk);
    chk("nw_no_more", nfr[0], 5);

    // Reset at frame cycle 50 with a parked sample and a load during reset.
    load_a(10'h0AA);
    repeat (19) @(negedge sysclk);
    bus_a.data_in = 10'h3C3; bus_a.load = 1'b1;
    @(negedge sysclk);
    bus_a.load = 1'b0;
    repeat (29) @(negedge sysclk);
    reset = 1'b1;
    bus_a.load = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    bus_a.load = 1'b0;
    chk("abort_cs",   bus_a.dac_cs,  1'b1);
    chk("abort_busy", bus_a.busy,    1'b0);
    chk("abort_ld",   bus_a.dac_ld,  HAS_LDAC);
    chk("abort_sck",  bus_a.dac_sck, 1'b0);
    chk("abort_sdi",  bus_a.dac_sdi, 1'b0);
    repeat (300) @(negedge sysclk);
    chk("abort_len",  r_busy[0][5], 50);
    chk("abort_none", nfr[0], 6);

    // CLK_DIV=1, BUF=1, GA_n=0.
    @(negedge sysclk);
    bus_b.data_in = 10'h155; bus_b.load = 1'b1;
    @(negedge sysclk);
    bus_b.load = 1'b0;
    wait_frames(1, 1, 200);
    chk("d1_word",   r_word[1][0], 16'h5554);
    chk("d1_busy",   r_busy[1][0], LEN);
    chk("d1_cs",     r_cs[1][0],   33);
    chk("d1_bits",   r_bits[1][0], 16);
    chk("d1_period", r_bad[1][0],  0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving sysclk cycles per SCK half-period (legal range 1..255).
REQ-002 The block SHALL have parameter BUF_EN, default 0, giving the value of the frame BUF bit.
REQ-003 The block SHALL have parameter GAIN_1X, default 1, giving the value of the frame GA_n bit.
REQ-004 The block SHALL have the port sysclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port data_in, input, 10 bits: offset-binary DAC sample, as produced by the sample processor.
REQ-007 The block SHALL have the port load, input, 1 bit: one-cycle strobe meaning data_in is valid.
REQ-008 The block SHALL have the port dac_cs, output, 1 bit: chip select, active low.
REQ-009 The block SHALL have the port dac_sck, output, 1 bit: serial clock, idle low.
REQ-010 The block SHALL have the port dac_sdi, output, 1 bit: serial data, MSB first.
REQ-011 The block SHALL have the port dac_ld, output, 1 bit: LDAC latch strobe, active low.
REQ-012 The block SHALL have the port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-013 The block SHALL use a 16-bit frame = {1'b0, BUF_EN, GAIN_1X, 1'b1 (SHDN_n), data[9:0], 2'b00}.
REQ-014 The block SHALL implement the FSM states IDLE, START, SHIFT, STOP and LDAC.
REQ-015 In IDLE, load=1 at edge N SHALL capture data_in into the shift register; at N+1 the state is START, with dac_cs=0, busy=1 and dac_sdi=frame[15].
REQ-016 START SHALL last CLK_DIV cycles with dac_sck=0.
REQ-017 SHIFT SHALL run 16 bits; each bit is dac_sck=1 for CLK_DIV cycles, then dac_sck=0 for CLK_DIV cycles.
REQ-018 In SHIFT, dac_sdi SHALL change only when dac_sck falls, so it is stable across every rising edge.
REQ-019 After the 16th low half-period, the block SHALL go to STOP: dac_cs=1, dac_sdi=0, for CLK_DIV cycles.
REQ-020 LDAC SHALL hold dac_ld=0 for CLK_DIV cycles and then return to IDLE, with busy=0 from the IDLE cycle onward.
REQ-021 Frame length from the first busy=1 cycle SHALL be 35*CLK_DIV cycles.
REQ-022 The block SHALL have a one-deep holding register: load while busy stores data_in and sets pend.
REQ-023 A further load while pend=1 SHALL overwrite the held value (newest wins).
REQ-024 On return to IDLE with pend=1, the next frame SHALL start at the next edge without waiting for load.
REQ-025 When the start from pend happens, pend SHALL clear.
REQ-026 load coincident with the LDAC→IDLE transition SHALL be treated as a busy-time load and go to the holding register.
REQ-027 The block SHALL send data_in bit-exact, with no offset or sign arithmetic.
REQ-028 The divider counter SHALL wrap at CLK_DIV-1.
REQ-029 The bit counter SHALL count 15 down to 0 with no wrap past 0.

Reset
REQ-030 reset=1 SHALL force, at the next edge: state IDLE, dac_cs=1, dac_sck=0, dac_sdi=0, dac_ld=1, busy=0, pend=0, counters 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately, with no STOP or LDAC phase.
REQ-032 The held sample SHALL be discarded on reset.
REQ-033 load during reset SHALL be ignored.

Configuration
REQ-034 The block SHALL provide the compile-time macro DAC_SPI_TX_LDAC_EN.
REQ-035 With DAC_SPI_TX_LDAC_EN defined, the LDAC state SHALL exist as in REQ-020 and the frame SHALL be 35*CLK_DIV cycles.
REQ-036 Without DAC_SPI_TX_LDAC_EN, the LDAC state SHALL be omitted, dac_ld SHALL be constant 0, STOP SHALL go directly to IDLE, and the frame SHALL be 34*CLK_DIV cycles.

Structure
REQ-037 Package dac_spi_pkg SHALL hold the state encoding, FRAME_W=16, DATA_W=10 and the frame bit positions (WR=15, BUF=14, GA=13, SHDN=12).
REQ-038 The block SHALL have one sub-module, sck_tick_gen, parameterised by CLK_DIV, that emits a 1-cycle half_tick when enabled and clears its count when disabled.

Verification
REQ-039 A bench SHALL cover: CLK_DIV=4, load with data_in=10'h200 → captured SDI bits 0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0; dac_cs low 132 cycles; busy high 140 cycles.
REQ-040 A bench SHALL cover: data_in=10'h3FF, then 10'h000 back-to-back → frames 16'h3FFC and 16'h3000 in order.
REQ-041 A bench SHALL cover: during a frame, loads of 10'h111 then 10'h222 → only 16'h3888 follows, starting one cycle after busy falls.
REQ-042 A bench SHALL cover: reset asserted at cycle 50 of a frame → next cycle shows dac_cs=1, busy=0, dac_ld=1, and no later frame without a new load.
REQ-043 A bench SHALL cover: build without DAC_SPI_TX_LDAC_EN → dac_ld constantly 0 and busy high 136 cycles at CLK_DIV=4.
REQ-044 A bench SHALL cover: CLK_DIV=1, BUF_EN=1, GAIN_1X=0, data_in=10'h155 → frame 16'h5554, dac_sck period 2 cycles.
